// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - glyph type, glyph constants, scan state enum and width helper
package sseg_pkg;

  typedef logic [6:0] glyph_t;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}
  localparam glyph_t GLYPH_BLANK = 7'h7F;
  localparam glyph_t GLYPH_T     = 7'b0000111;
  localparam glyph_t GLYPH_D     = 7'b0100001;
  localparam glyph_t GLYPH_N     = 7'b0101011;
  localparam glyph_t GLYPH_R     = 7'b0101111;
  localparam glyph_t GLYPH_0     = 7'b1000000;
  localparam glyph_t GLYPH_1     = 7'b1111001;
  localparam glyph_t GLYPH_2     = 7'b0100100;
  localparam glyph_t GLYPH_3     = 7'b0110000;
  localparam glyph_t GLYPH_4     = 7'b0011001;
  localparam glyph_t GLYPH_5     = 7'b0010010;
  localparam glyph_t GLYPH_6     = 7'b0000010;
  localparam glyph_t GLYPH_7     = 7'b1111000;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0010000;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// rtl/sseg_scan_timer.sv - slot counter, digit index and slot-start pulse
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SLOT_CYC = 25000,
  localparam int IDX_W   = idx_width(DIGITS),
  localparam int CNT_W   = idx_width(SLOT_CYC)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_slot_cnt,
  output logic [IDX_W-1:0] o_digit_idx,
  output logic             o_slot_tick
);

  logic [CNT_W-1:0] r_slot_cnt;
  logic [IDX_W-1:0] r_digit_idx;
  logic             r_slot_tick;

  // The tick register is loaded with "next count is zero" so it lines up with slot_cnt == 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_slot_tick <= 1'b0;
    end else if (r_slot_cnt == CNT_W'(SLOT_CYC - 1)) begin
      r_slot_cnt  <= '0;
      r_slot_tick <= 1'b1;
      if (r_digit_idx == IDX_W'(DIGITS - 1)) r_digit_idx <= '0;
      else                                   r_digit_idx <= r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
      r_slot_tick <= 1'b0;
    end
  end

  assign o_slot_cnt  = r_slot_cnt;
  assign o_digit_idx = r_digit_idx;
  assign o_slot_tick = r_slot_tick;

endmodule

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - multiplexed 7-segment driver with glyph regs, override and optional blink (SSEG_BLINK_EN)
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 25000,
  parameter int BLANK_CYC = 2,
  parameter int OVR_DIGIT = DIGITS - 1,
  parameter int BLINK_CYC = 50_000_000,
  localparam int IDX_W    = idx_width(DIGITS),
  localparam int CNT_W    = idx_width(SLOT_CYC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [6:0]        wr_glyph,
  input  logic              override_active,
  input  logic [6:0]        override_char,
  input  logic [DIGITS-1:0] blink_mask,
  output logic [DIGITS-1:0] an_out,
  output logic [6:0]        char_out,
  output logic              slot_tick
);

  logic [CNT_W-1:0]  w_slot_cnt;
  logic [IDX_W-1:0]  w_digit_idx;
  logic              w_slot_tick;
  logic              w_in_blank;
  logic              w_blink_off;
  glyph_t            w_glyph;
  logic [DIGITS-1:0] w_an_on;

  glyph_t            r_glyph [DIGITS];
  scan_state_t       r_state;
  logic [DIGITS-1:0] r_an_out;
  glyph_t            r_char_out;

  sseg_scan_timer #(
    .DIGITS  (DIGITS),
    .SLOT_CYC(SLOT_CYC)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_slot_cnt (w_slot_cnt),
    .o_digit_idx(w_digit_idx),
    .o_slot_tick(w_slot_tick)
  );

  // Indices outside 0..DIGITS-1 match no register, so such writes fall away
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (rst)                                      r_glyph[i] <= GLYPH_BLANK;
      else if (wr_en && (wr_idx == IDX_W'(i)))      r_glyph[i] <= wr_glyph;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BLK_W = idx_width(BLINK_CYC);
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLK_W'(BLINK_CYC - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blink_off = r_blink_phase & blink_mask[w_digit_idx];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_off    = 1'b0;
`endif

  assign w_in_blank = (BLANK_CYC > 0) && (32'(w_slot_cnt) < BLANK_CYC);
  assign w_an_on    = ~(DIGITS'(1) << w_digit_idx);

  always_comb begin
    w_glyph = r_glyph[w_digit_idx];
    if (override_active)  w_glyph = (w_digit_idx == IDX_W'(OVR_DIGIT)) ? override_char : GLYPH_BLANK;
    else if (w_blink_off) w_glyph = GLYPH_BLANK;
  end

  // Outputs default dark each cycle; only the ON path drives an anode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BLANK;
      r_an_out   <= '1;
      r_char_out <= GLYPH_BLANK;
    end else begin
      r_an_out   <= '1;
      r_char_out <= GLYPH_BLANK;
      unique case (r_state)
        BLANK: begin
          if (!w_in_blank) begin
            r_state    <= ON;
            r_an_out   <= w_an_on;
            r_char_out <= w_glyph;
          end
        end
        ON: begin
          if (w_in_blank) begin
            r_state    <= BLANK;
          end else begin
            r_an_out   <= w_an_on;
            r_char_out <= w_glyph;
          end
        end
        default: r_state <= BLANK;
      endcase
    end
  end

  assign an_out    = r_an_out;
  assign char_out  = r_char_out;
  assign slot_tick = w_slot_tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - randomized bench against a cycle-count based display model
module tb_sseg_scan_driver;

  localparam int SLOT  = 8;
  localparam int BLK   = 2;
  localparam int BLINK = 64;
`ifdef SSEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [6:0] wr_glyph = '0;
  logic       override_active = 1'b0;
  logic [6:0] override_char = 7'b0000111;
  logic [3:0] blink_mask = '0;
  logic [3:0] an_out;
  logic [6:0] char_out;
  logic       slot_tick;

  logic       wr3_en = 1'b0;
  logic [1:0] wr3_idx = '0;
  logic [6:0] wr3_glyph = '0;
  logic       ovr3 = 1'b0;
  logic [6:0] ovc3 = 7'h7F;
  logic [2:0] bm3 = '0;
  logic [2:0] an3;
  logic [6:0] ch3;
  logic       tick3;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;
  logic [6:0] g4 [8];
  logic [6:0] g3 [8];

  always #5 clk = ~clk;

  sseg_scan_driver #(.DIGITS(4), .SLOT_CYC(SLOT), .BLANK_CYC(BLK), .OVR_DIGIT(3), .BLINK_CYC(BLINK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_glyph(wr_glyph),
    .override_active(override_active), .override_char(override_char), .blink_mask(blink_mask),
    .an_out(an_out), .char_out(char_out), .slot_tick(slot_tick));

  sseg_scan_driver #(.DIGITS(3), .SLOT_CYC(SLOT), .BLANK_CYC(BLK), .BLINK_CYC(BLINK)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr3_en), .wr_idx(wr3_idx), .wr_glyph(wr3_glyph),
    .override_active(ovr3), .override_char(ovc3), .blink_mask(bm3),
    .an_out(an3), .char_out(ch3), .slot_tick(tick3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  // Display for the cycle n positions after reset release; returns {an[7:0], char[6:0]}
  function automatic logic [14:0] model_out(input int cyc, input int nd, input logic [6:0] g [8],
                                            input logic ovr, input logic [6:0] oc, input logic [7:0] bm);
    int pos, d;
    logic [6:0] ch;
    logic [7:0] an;
    pos = cyc % SLOT;
    d   = (cyc / SLOT) % nd;
    if (pos < BLK) return {8'hFF, 7'h7F};
    an = ~(8'd1 << d);
    ch = g[d];
    if (ovr) ch = (d == nd - 1) ? oc : 7'h7F;
    else if (BLINK_ON && bm[d] && ((cyc / BLINK) % 2 == 1)) ch = 7'h7F;
    return {an, ch};
  endfunction

  task automatic step();
    logic [14:0] e4, e3;
    logic        was_rst, e_tick;
    int          nn;
    e4 = model_out(n, 4, g4, override_active, override_char, {4'b0, blink_mask});
    e3 = model_out(n, 3, g3, 1'b0, 7'h7F, 8'h0);
    was_rst = rst;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin g4[i] = 7'h7F; g3[i] = 7'h7F; end
    end else begin
      if (wr_en) g4[wr_idx] = wr_glyph;
      if (wr3_en && wr3_idx < 2'd3) g3[wr3_idx] = wr3_glyph;
    end
    nn = was_rst ? 0 : n + 1;
    e_tick = !was_rst && (nn % SLOT == 0) && (nn >= SLOT);
    @(posedge clk);
    #1;
    n = nn;
    if (was_rst) begin
      e4 = {8'hFF, 7'h7F};
      e3 = {8'hFF, 7'h7F};
    end
    check("an4",   an_out,    e4[10:7]);
    check("char4", char_out,  e4[6:0]);
    check("tick4", slot_tick, e_tick);
    check("an3",   an3,       e3[9:7]);
    check("char3", ch3,       e3[6:0]);
    check("tick3", tick3,     e_tick);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin g4[i] = 7'h7F; g3[i] = 7'h7F; end
    #1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Scan order with D,N,R,T
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i);
      case (i)
        0: wr_glyph = 7'b0100001;
        1: wr_glyph = 7'b0101011;
        2: wr_glyph = 7'b0101111;
        default: wr_glyph = 7'b0000111;
      endcase
      wr3_en = 1'b1; wr3_idx = 2'(i); wr3_glyph = 7'(8'h11 * (i + 1));
      step();
    end
    wr_en = 1'b0; wr3_en = 1'b0;
    repeat (40) step();

    // Override on digit 3, then release
    override_active = 1'b1; override_char = 7'b0000111;
    repeat (34) step();
    override_active = 1'b0;
    repeat (12) step();

    // Write digit 1 right after it turns on
    for (int k = 0; k < 64 && !((n % SLOT == 3) && ((n / SLOT) % 4 == 1)); k++) step();
    wr_en = 1'b1; wr_idx = 2'd1; wr_glyph = 7'h40;
    step();
    wr_en = 1'b0;
    repeat (8) step();

    // Simultaneous write and override
    override_active = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd3; wr_glyph = 7'h55;
    step();
    wr_en = 1'b0;
    repeat (20) step();
    override_active = 1'b0;
    repeat (12) step();

    // Reset mid-slot on digit 2
    for (int k = 0; k < 64 && !((n % SLOT == 5) && ((n / SLOT) % 4 == 2)); k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();

    // Blink on digit 1, override on digit 3 with blink_mask[3] set
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_glyph = 7'(7'h10 + i);
      step();
    end
    wr_en = 1'b0;
    blink_mask = 4'b0010;
    repeat (280) step();
    blink_mask = 4'b1010; override_active = 1'b1;
    repeat (140) step();
    override_active = 1'b0;

    // Random traffic, including out-of-range writes to the 3-digit instance
    for (int i = 0; i < 600; i++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_idx    = 2'($urandom_range(0, 3));
      wr_glyph  = 7'($urandom);
      wr3_en    = ($urandom_range(0, 2) == 0);
      wr3_idx   = 2'($urandom_range(0, 3));
      wr3_glyph = 7'($urandom);
      if ($urandom_range(0, 15) == 0) override_active = ~override_active;
      if ($urandom_range(0, 7) == 0) override_char = 7'($urandom);
      if (i % 50 == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0; wr3_en = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
